// File: rtl/sc_cond_eval_pkg.sv
// Shared types and SPARC Bicc condition codes for the branch condition evaluator.
package sc_cond_eval_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BN   = 4'h0;
    localparam logic [3:0] BE   = 4'h1;
    localparam logic [3:0] BLE  = 4'h2;
    localparam logic [3:0] BL   = 4'h3;
    localparam logic [3:0] BLEU = 4'h4;
    localparam logic [3:0] BCS  = 4'h5;
    localparam logic [3:0] BNEG = 4'h6;
    localparam logic [3:0] BVS  = 4'h7;
    localparam logic [3:0] BA   = 4'h8;
    localparam logic [3:0] BNE  = 4'h9;
    localparam logic [3:0] BG   = 4'hA;
    localparam logic [3:0] BGE  = 4'hB;
    localparam logic [3:0] BGU  = 4'hC;
    localparam logic [3:0] BCC  = 4'hD;
    localparam logic [3:0] BPOS = 4'hE;
    localparam logic [3:0] BVC  = 4'hF;

endpackage

// File: rtl/sc_cond_eval_table.sv
// Combinational Bicc decoder: condition code plus N/Z/V/C flags to a branch decision.
module sc_cond_eval_table
    import sc_cond_eval_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic       n_i,
    input  logic       z_i,
    input  logic       v_i,
    input  logic       c_i,
    output logic       decision_o
);

    // Decision per condition code
    always_comb begin
        decision_o = 1'b0;
        case (cond_i)
            BN:      decision_o = 1'b0;
            BE:      decision_o = z_i;
            BLE:     decision_o = z_i | (n_i ^ v_i);
            BL:      decision_o = n_i ^ v_i;
            BLEU:    decision_o = c_i | z_i;
            BCS:     decision_o = c_i;
            BNEG:    decision_o = n_i;
            BVS:     decision_o = v_i;
            BA:      decision_o = 1'b1;
            BNE:     decision_o = ~z_i;
            BG:      decision_o = ~(z_i | (n_i ^ v_i));
            BGE:     decision_o = ~(n_i ^ v_i);
            BGU:     decision_o = ~(c_i | z_i);
            BCC:     decision_o = ~c_i;
            BPOS:    decision_o = ~n_i;
            BVC:     decision_o = ~v_i;
            default: decision_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sc_cond_eval.sv
// Branch condition evaluator: waits out pending PSR writes, then decodes Bicc.
// Optional delay-slot annul output is enabled by defining COND_EVAL_ANNUL_EN.
module sc_cond_eval
    import sc_cond_eval_pkg::*;
#(
    parameter int WAIT_MAX = 3
) (
    input  logic       SC_CondEval_CLOCK_50,
    input  logic       SC_CondEval_Reset_InHigh,
    input  logic       SC_CondEval_Start_InHigh,
    input  logic [3:0] SC_CondEval_Cond,
    input  logic       SC_CondEval_Annul_InHigh,
    input  logic       PSR_Negative_InHigh,
    input  logic       PSR_Zero_InHigh,
    input  logic       PSR_Overflow_InHigh,
    input  logic       PSR_Carry_InHigh,
    input  logic       SC_RegPSR_Write_InHigh,
    output logic       SC_CondEval_Busy_InHigh,
    output logic       SC_CondEval_Valid_InHigh,
    output logic       SC_CondEval_Taken_InHigh,
    output logic       SC_CondEval_AnnulOut_InHigh
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    state_t             state_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [3:0]         cond_q;
    logic               busy_q;
    logic               valid_q;
    logic               taken_q;
    logic               decision_s;
    logic               wait_exit_s;
    logic               accept_s;

    assign accept_s    = (state_q == ST_IDLE) && SC_CondEval_Start_InHigh;
    assign wait_exit_s = !SC_RegPSR_Write_InHigh || (wait_cnt_q == CNT_W'(WAIT_MAX - 1));

    sc_cond_eval_table u_table (
        .cond_i     (cond_q),
        .n_i        (PSR_Negative_InHigh),
        .z_i        (PSR_Zero_InHigh),
        .v_i        (PSR_Overflow_InHigh),
        .c_i        (PSR_Carry_InHigh),
        .decision_o (decision_s)
    );

    // Control FSM with registered status outputs
    always_ff @(posedge SC_CondEval_CLOCK_50) begin
        if (SC_CondEval_Reset_InHigh) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            cond_q     <= 4'h0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    valid_q <= 1'b0;
                    if (accept_s) begin
                        cond_q     <= SC_CondEval_Cond;
                        wait_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SC_RegPSR_Write_InHigh ? ST_WAIT : ST_EVAL;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    if (wait_exit_s) begin
                        state_q <= ST_EVAL;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                // Flags are sampled here; the decision becomes visible with Valid
                ST_EVAL: begin
                    taken_q <= decision_s;
                    valid_q <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef COND_EVAL_ANNUL_EN
    logic annul_q;
    logic annul_out_q;

    // Annul capture at accept and delay-slot annul decision in EVAL
    always_ff @(posedge SC_CondEval_CLOCK_50) begin
        if (SC_CondEval_Reset_InHigh) begin
            annul_q     <= 1'b0;
            annul_out_q <= 1'b0;
        end else begin
            if (accept_s) begin
                annul_q <= SC_CondEval_Annul_InHigh;
            end
            if (state_q == ST_EVAL) begin
                annul_out_q <= annul_q & (~decision_s | (cond_q == BA));
            end
        end
    end

    assign SC_CondEval_AnnulOut_InHigh = annul_out_q;
`else
    logic annul_unused_s;
    assign annul_unused_s              = SC_CondEval_Annul_InHigh;
    assign SC_CondEval_AnnulOut_InHigh = 1'b0;
`endif

    assign SC_CondEval_Busy_InHigh  = busy_q;
    assign SC_CondEval_Valid_InHigh = valid_q;
    assign SC_CondEval_Taken_InHigh = taken_q;

endmodule

// File: doc/sc_cond_eval.md
SC_COND_EVAL -- requirements
Module: sc_cond_eval

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 3: maximum consecutive cycles spent in WAIT.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports named as below (polarity and synchronicity fixed).
REQ-003 SC_CondEval_CLOCK_50  in  1  system clock; all state updates on rising edge.
REQ-004 SC_CondEval_Reset_InHigh  in  1  synchronous active-high reset.
REQ-005 SC_CondEval_Start_InHigh  in  1  evaluation request; accepted only in IDLE.
REQ-006 SC_CondEval_Cond  in  4  branch condition code (SPARC Bicc encoding), captured at accept.
REQ-007 SC_CondEval_Annul_InHigh  in  1  annul bit of branch, captured at accept (used only when COND_EVAL_ANNUL_EN is defined).
REQ-008 PSR_Negative_InHigh, PSR_Zero_InHigh, PSR_Overflow_InHigh, PSR_Carry_InHigh  in  1 each  flags from the PSR register.
REQ-009 SC_RegPSR_Write_InHigh  in  1  PSR flag update pending this cycle.
REQ-010 SC_CondEval_Busy_InHigh  out  1  high in WAIT, EVAL, DONE.
REQ-011 SC_CondEval_Valid_InHigh  out  1  one-cycle result strobe.
REQ-012 SC_CondEval_Taken_InHigh  out  1  branch decision; holds until next DONE.
REQ-013 SC_CondEval_AnnulOut_InHigh  out  1  delay-slot annul; constant 0 when macro is undefined.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, EVAL, DONE.
REQ-015 IDLE: Start & !PSRWrite -> EVAL; Start & PSRWrite -> WAIT (wait counter cleared); Cond/Annul captured on any accept.
REQ-016 WAIT: counter increments each cycle; -> EVAL when PSRWrite low or counter reaches WAIT_MAX-1; else stay.
REQ-017 EVAL: SHALL sample the four PSR flags, compute the decision, and register it into Taken; -> DONE.
REQ-018 DONE: Valid=1 for exactly this cycle; -> IDLE unconditionally.
REQ-019 Start asserted outside IDLE SHALL be ignored (no queueing).
REQ-020 Latency: Start at cycle t without write -> Valid at t+2; with one write cycle -> Valid at t+3; WAIT never exceeds WAIT_MAX cycles.
REQ-021 Decision: Cond[2:0] selects 0 false, 1 Z, 2 Z|(N^V), 3 N^V, 4 C|Z, 5 C, 6 N, 7 V; Cond[3]=1 SHALL invert the selected term (8=always, 9=!Z, ... F=!V).
REQ-022 Taken and AnnulOut SHALL change only on the EVAL->DONE transition.

Reset
REQ-023 Reset SHALL force IDLE, clear the wait counter and captured Cond/Annul, and set Busy, Valid, Taken, AnnulOut to 0 on the next rising edge, including mid-operation (WAIT/EVAL/DONE aborted; no Valid).
REQ-024 Reset SHALL take priority over Start in the same cycle.

Configuration
REQ-025 With COND_EVAL_ANNUL_EN defined, AnnulOut SHALL equal captured Annul & (!decision | Cond==4'h8), registered in EVAL.
REQ-026 Without COND_EVAL_ANNUL_EN, the Annul input SHALL be unused, and AnnulOut SHALL be tied to 0 with no annul storage.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef and the 16 condition-code constants (BN..BVC), reused by the decoder.
REQ-028 A combinational sub-module sc_cond_eval_table (Cond + flags -> decision) SHALL be instantiated once.

Verification
REQ-029 Cond=4'h1, Z=1, no write, Start at t -> Valid at t+2, Taken=1.
REQ-030 Cond=4'hA (BG), N=1, V=0, Z=0 -> Taken=0; then N=1, V=1 -> Taken=1.
REQ-031 PSRWrite high at Start and the next cycle; Z changes 0->1 while waiting; Cond=4'h1 -> Valid at t+4, Taken=1.
REQ-032 PSRWrite held high continuously with WAIT_MAX=3 -> exits WAIT after 3 cycles, Valid at t+5.
REQ-033 Reset asserted in EVAL -> next cycle IDLE, Busy=0, no Valid, Taken=0.
REQ-034 Macro defined: Cond=4'h8, Annul=1 -> Taken=1, AnnulOut=1; Cond=4'h1, Z=0, Annul=1 -> AnnulOut=1; Cond=4'h1, Z=1, Annul=1 -> AnnulOut=0.
